// File: rtl/positron_layer_weight_sequencer.sv
// Weight-row store and activation sequencer for one positron layer: pairs each
// accepted posit with its weight row and marks frame boundaries.
module positron_layer_weight_sequencer #(
  parameter int NB_UPSTREAM_POSITRON = 784,
  parameter int NB_POSITRON          = 20,
  parameter int POSIT_WIDTH          = 16,
  parameter int WEIGHT_WIDTH         = 8,
  parameter int FRAME_CNT_WIDTH      = 16,
  localparam int AW = (NB_UPSTREAM_POSITRON > 1) ? $clog2(NB_UPSTREAM_POSITRON) : 1,
  localparam int RW = NB_POSITRON * WEIGHT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we_i,
  input  logic [AW-1:0]              cfg_addr_i,
  input  logic [RW-1:0]              cfg_data_i,
  input  logic                       cfg_commit_i,
  input  logic                       cfg_reload_i,
  output logic                       cfg_err_o,
  output logic                       loaded_o,
  output logic                       rtr_o,
  input  logic                       rts_i,
  input  logic                       eow_i,
  input  logic [POSIT_WIDTH-1:0]     posit_i,
  input  logic                       rtr_i,
  output logic                       rts_o,
  output logic                       sow_o,
  output logic                       eow_o,
  output logic                       dma_eow_o,
  output logic [POSIT_WIDTH-1:0]     posit_o,
  output logic [RW-1:0]              weights_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NB_UPSTREAM_POSITRON - 1);

  state_e                     state_q, state_d;
  logic [AW-1:0]              wc_q, wc_d;
  logic                       reload_pending_q, reload_pending_d;
  logic                       rts_q, rts_d;
  logic                       sow_q, sow_d;
  logic                       eow_q, eow_d;
  logic                       dma_eow_q, dma_eow_d;
  logic [POSIT_WIDTH-1:0]     posit_q, posit_d;
  logic [RW-1:0]              weights_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       cfg_err_q, cfg_err_d;
  logic [RW-1:0]              mem_q [NB_UPSTREAM_POSITRON];

  logic rtr_s, accept_s, xfer_s, frame_end_s;

  // Handshake decode: a single output register gives full throughput.
  always_comb begin
    rtr_s = 1'b0;
    if (state_q == ST_RUN && !(reload_pending_q && wc_q == '0)) begin
      rtr_s = ~rts_q | rtr_i;
    end else begin
      rtr_s = 1'b0;
    end
    xfer_s      = rts_q & rtr_i;
    accept_s    = rts_i & rtr_s;
    frame_end_s = (wc_q == LAST_IDX) | eow_i;
  end

  // Next-state for the FSM, frame indexing and output word fields.
  always_comb begin
    state_d          = state_q;
    wc_d             = wc_q;
    reload_pending_d = reload_pending_q;
    rts_d            = rts_q;
    sow_d            = sow_q;
    eow_d            = eow_q;
    dma_eow_d        = dma_eow_q;
    posit_d          = posit_q;
    frame_cnt_d      = frame_cnt_q;
    cfg_err_d        = cfg_err_q;

    if (accept_s) begin
      rts_d     = 1'b1;
      sow_d     = (wc_q == '0);
      eow_d     = frame_end_s;
      dma_eow_d = eow_i;
      posit_d   = posit_i;
      wc_d      = frame_end_s ? '0 : wc_q + AW'(1'b1);
    end else if (xfer_s) begin
      rts_d = 1'b0;
    end else begin
      rts_d = rts_q;
    end

    if (xfer_s && eow_q) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1'b1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    if (cfg_we_i && state_q != ST_LOAD) begin
      cfg_err_d = 1'b1;
    end else begin
      cfg_err_d = cfg_err_q;
    end

    case (state_q)
      ST_LOAD: begin
        if (cfg_commit_i) begin
          state_d = ST_RUN;
          wc_d    = '0;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (cfg_reload_i) begin
          reload_pending_d = 1'b1;
        end else begin
          reload_pending_d = reload_pending_q;
        end
        // Leave only on a frame boundary, judged on the post-accept counter.
        if (reload_pending_d && wc_d == '0) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!rts_q || xfer_s) begin
          state_d          = ST_LOAD;
          reload_pending_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d          = ST_LOAD;
        reload_pending_d = 1'b0;
      end
    endcase
  end

  // State and output registers; weights_o is the synchronous memory read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_LOAD;
      wc_q             <= '0;
      reload_pending_q <= 1'b0;
      rts_q            <= 1'b0;
      sow_q            <= 1'b0;
      eow_q            <= 1'b0;
      dma_eow_q        <= 1'b0;
      posit_q          <= '0;
      weights_q        <= '0;
      frame_cnt_q      <= '0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      wc_q             <= wc_d;
      reload_pending_q <= reload_pending_d;
      rts_q            <= rts_d;
      sow_q            <= sow_d;
      eow_q            <= eow_d;
      dma_eow_q        <= dma_eow_d;
      posit_q          <= posit_d;
      frame_cnt_q      <= frame_cnt_d;
      cfg_err_q        <= cfg_err_d;
      if (accept_s) begin
        weights_q <= mem_q[wc_q];
      end
    end
  end

  // Weight memory write port, open only while loading.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && cfg_we_i) begin
      mem_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign rtr_o       = rtr_s;
  assign loaded_o    = (state_q == ST_RUN);
  assign cfg_err_o   = cfg_err_q;
  assign rts_o       = rts_q;
  assign sow_o       = sow_q;
  assign eow_o       = eow_q;
  assign dma_eow_o   = dma_eow_q;
  assign posit_o     = posit_q;
  assign weights_o   = weights_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_positron_layer_weight_sequencer.sv
// Directed bench for positron_layer_weight_sequencer with a 4-word frame and
// 2 positrons of 8-bit weights.
module tb_positron_layer_weight_sequencer;

  localparam int N   = 4;
  localparam int P   = 2;
  localparam int PW  = 16;
  localparam int WW  = 8;
  localparam int FCW = 16;
  localparam int AW  = 2;
  localparam int RW  = P * WW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we_i, cfg_commit_i, cfg_reload_i;
  logic [AW-1:0]  cfg_addr_i;
  logic [RW-1:0]  cfg_data_i;
  logic           cfg_err_o, loaded_o, rtr_o;
  logic           rts_i, eow_i, rtr_i;
  logic [PW-1:0]  posit_i;
  logic           rts_o, sow_o, eow_o, dma_eow_o;
  logic [PW-1:0]  posit_o;
  logic [RW-1:0]  weights_o;
  logic [FCW-1:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  positron_layer_weight_sequencer #(
    .NB_UPSTREAM_POSITRON(N),
    .NB_POSITRON(P),
    .POSIT_WIDTH(PW),
    .WEIGHT_WIDTH(WW),
    .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_commit_i(cfg_commit_i), .cfg_reload_i(cfg_reload_i),
    .cfg_err_o(cfg_err_o), .loaded_o(loaded_o), .rtr_o(rtr_o),
    .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i), .rtr_i(rtr_i),
    .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .dma_eow_o(dma_eow_o),
    .posit_o(posit_o), .weights_o(weights_o), .frame_cnt_o(frame_cnt_o)
  );

  // Row k holds 0x0101 * (k+1): 0x0101, 0x0202, 0x0303, 0x0404.
  function automatic logic [RW-1:0] row_w(input int k);
    return RW'(32'h0101 * (k + 1));
  endfunction

  task automatic drive_idle();
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0; cfg_commit_i = 1'b0;
    cfg_reload_i = 1'b0; rts_i = 1'b0; eow_i = 1'b0; posit_i = '0; rtr_i = 1'b1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Last row written in the same cycle as commit.
  task automatic load_rows();
    for (int k = 0; k < N; k++) begin
      cfg_we_i = 1'b1; cfg_addr_i = AW'(k); cfg_data_i = row_w(k);
      cfg_commit_i = (k == N - 1);
      @(negedge clk);
    end
    cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rts_o, sow_o, eow_o, dma_eow_o, posit_o, weights_o, rtr_o, loaded_o, cfg_err_o, frame_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rts=%b sow=%b eow=%b dma=%b posit=%h w=%h rtr=%b loaded=%b err=%b fc=%0d, required all zero",
               rts_o, sow_o, eow_o, dma_eow_o, posit_o, weights_o, rtr_o, loaded_o, cfg_err_o, frame_cnt_o);
    end
    rts_i = 1'b1; #1;
    n_checks++;
    if (rtr_o !== 1'b0) begin n_fail++; $display("FAIL reset_load_rtr: got %b, required 0", rtr_o); end
    rts_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [PW-1:0] exp_p;
    logic [RW-1:0] exp_w;
    logic exp_sow, exp_eow;
    do_reset();
    load_rows();
    #1;
    n_checks++;
    if (loaded_o !== 1'b1 || rtr_o !== 1'b1) begin
      n_fail++; $display("FAIL stream_run_entry: loaded=%b rtr=%b, required 1 1", loaded_o, rtr_o);
    end
    rts_i = 1'b1; posit_i = 16'h0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_p = PW'(32'h10 + i); exp_w = row_w(i % 4);
      exp_sow = ((i % 4) == 0); exp_eow = ((i % 4) == 3);
      n_checks++;
      if (rts_o !== 1'b1 || posit_o !== exp_p || weights_o !== exp_w || sow_o !== exp_sow || eow_o !== exp_eow || dma_eow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_word%0d: got rts=%b posit=%h w=%h sow=%b eow=%b dma=%b, required 1 %h %h %b %b 0",
                 i, rts_o, posit_o, weights_o, sow_o, eow_o, dma_eow_o, exp_p, exp_w, exp_sow, exp_eow);
      end
      if (i < 7) posit_i = PW'(32'h11 + i);
      else rts_i = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (rts_o !== 1'b0 || frame_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL stream_end: rts=%b frame_cnt=%0d, required 0 2", rts_o, frame_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_rows();
    rts_i = 1'b1; posit_i = 16'h0010;
    @(negedge clk);
    n_checks++;
    if (posit_o !== 16'h0010 || weights_o !== 16'h0101) begin
      n_fail++; $display("FAIL bp_word0: posit=%h w=%h, required 0010 0101", posit_o, weights_o);
    end
    posit_i = 16'h0011;
    @(negedge clk);
    posit_i = 16'h0012; rtr_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if (rtr_o !== 1'b0 || rts_o !== 1'b1 || posit_o !== 16'h0011 || weights_o !== 16'h0202 || sow_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: rtr=%b rts=%b posit=%h w=%h sow=%b, required 0 1 0011 0202 0",
                 s, rtr_o, rts_o, posit_o, weights_o, sow_o);
      end
      @(negedge clk);
    end
    rtr_i = 1'b1; #1;
    n_checks++;
    if (rtr_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_rtr: got %b, required 1", rtr_o); end
    @(negedge clk);
    n_checks++;
    if (rts_o !== 1'b1 || posit_o !== 16'h0012 || weights_o !== 16'h0303) begin
      n_fail++; $display("FAIL bp_word2: rts=%b posit=%h w=%h, required 1 0012 0303", rts_o, posit_o, weights_o);
    end
    posit_i = 16'h0013;
    @(negedge clk);
    n_checks++;
    if (posit_o !== 16'h0013 || weights_o !== 16'h0404 || eow_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_word3: posit=%h w=%h eow=%b, required 0013 0404 1", posit_o, weights_o, eow_o);
    end
    rts_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rts_o !== 1'b0 || frame_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL bp_end: rts=%b frame_cnt=%0d, required 0 1", rts_o, frame_cnt_o);
    end
  endtask

  // Words 1 and 5 carry eow_i; word 5 also sits at the last frame index.
  task automatic test_truncated();
    int            tr_idx [7] = '{0, 1, 0, 1, 2, 3, 0};
    logic [PW-1:0] exp_p;
    logic [RW-1:0] exp_w;
    logic          in_eow, exp_sow, exp_eow;
    do_reset();
    load_rows();
    rts_i = 1'b1; posit_i = 16'h0020; eow_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_eow = (i == 1) || (i == 5);
      eow_i = in_eow;
      @(negedge clk);
      exp_p = PW'(32'h20 + i); exp_w = row_w(tr_idx[i]);
      exp_sow = (tr_idx[i] == 0); exp_eow = in_eow || (tr_idx[i] == 3);
      n_checks++;
      if (posit_o !== exp_p || weights_o !== exp_w || sow_o !== exp_sow || eow_o !== exp_eow || dma_eow_o !== in_eow) begin
        n_fail++;
        $display("FAIL trunc_word%0d: got posit=%h w=%h sow=%b eow=%b dma=%b, required %h %h %b %b %b",
                 i, posit_o, weights_o, sow_o, eow_o, dma_eow_o, exp_p, exp_w, exp_sow, exp_eow, in_eow);
      end
      posit_i = PW'(32'h21 + i);
    end
    rts_i = 1'b0; eow_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL trunc_frame_cnt: got %0d, required 2", frame_cnt_o);
    end
  endtask

  task automatic test_reload();
    do_reset();
    load_rows();
    rts_i = 1'b1; posit_i = 16'h0040;
    @(negedge clk);
    posit_i = 16'h0041;
    @(negedge clk);
    posit_i = 16'h0042; cfg_reload_i = 1'b1;
    @(negedge clk);
    cfg_reload_i = 1'b0; posit_i = 16'h0043; #1;
    n_checks++;
    if (rtr_o !== 1'b1 || loaded_o !== 1'b1) begin
      n_fail++; $display("FAIL reload_still_run: rtr=%b loaded=%b, required 1 1", rtr_o, loaded_o);
    end
    @(negedge clk);
    posit_i = 16'h0044; #1;
    n_checks++;
    if (rts_o !== 1'b1 || posit_o !== 16'h0043 || eow_o !== 1'b1 || rtr_o !== 1'b0 || loaded_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_drain: rts=%b posit=%h eow=%b rtr=%b loaded=%b, required 1 0043 1 0 0",
               rts_o, posit_o, eow_o, rtr_o, loaded_o);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rts_o !== 1'b0 || rtr_o !== 1'b0 || loaded_o !== 1'b0 || frame_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL reload_in_load: rts=%b rtr=%b loaded=%b frame_cnt=%0d, required 0 0 0 1",
               rts_o, rtr_o, loaded_o, frame_cnt_o);
    end
    rts_i = 1'b0;
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 16'hAAAA;
    @(negedge clk);
    cfg_we_i = 1'b0; cfg_commit_i = 1'b1;
    @(negedge clk);
    cfg_commit_i = 1'b0; #1;
    n_checks++;
    if (loaded_o !== 1'b1) begin n_fail++; $display("FAIL reload_recommit: loaded=%b, required 1", loaded_o); end
    rts_i = 1'b1; posit_i = 16'h0050;
    @(negedge clk);
    n_checks++;
    if (posit_o !== 16'h0050 || weights_o !== 16'hAAAA || sow_o !== 1'b1 || cfg_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_new_row0: posit=%h w=%h sow=%b err=%b, required 0050 aaaa 1 0",
               posit_o, weights_o, sow_o, cfg_err_o);
    end
    rts_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cfg_err();
    do_reset();
    load_rows();
    n_checks++;
    if (cfg_err_o !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b, required 0", cfg_err_o); end
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 16'h5555;
    @(negedge clk);
    cfg_we_i = 1'b0;
    n_checks++;
    if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, required 1", cfg_err_o); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (cfg_err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", cfg_err_o); end
    rts_i = 1'b1; posit_i = 16'h0060;
    @(negedge clk);
    n_checks++;
    if (weights_o !== 16'h0101 || sow_o !== 1'b1) begin
      n_fail++; $display("FAIL err_mem_intact: w=%h sow=%b, required 0101 1", weights_o, sow_o);
    end
    rts_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    load_rows();
    rts_i = 1'b1; posit_i = 16'h0070;
    @(negedge clk);
    posit_i = 16'h0071; rtr_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rts_o !== 1'b1 || posit_o !== 16'h0070) begin
      n_fail++; $display("FAIL arst_precond: rts=%b posit=%h, required 1 0070", rts_o, posit_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rts_o, sow_o, eow_o, dma_eow_o, posit_o, weights_o, rtr_o, loaded_o, cfg_err_o, frame_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL arst_outputs: rts=%b sow=%b eow=%b dma=%b posit=%h w=%h rtr=%b loaded=%b fc=%0d, required all zero",
               rts_o, sow_o, eow_o, dma_eow_o, posit_o, weights_o, rtr_o, loaded_o, frame_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rtr_o !== 1'b0 || loaded_o !== 1'b0 || rts_o !== 1'b0) begin
      n_fail++; $display("FAIL arst_load: rtr=%b loaded=%b rts=%b, required 0 0 0", rtr_o, loaded_o, rts_o);
    end
    cfg_commit_i = 1'b1;
    @(negedge clk);
    cfg_commit_i = 1'b0; #1;
    n_checks++;
    if (rtr_o !== 1'b1 || loaded_o !== 1'b1) begin
      n_fail++; $display("FAIL arst_commit: rtr=%b loaded=%b, required 1 1", rtr_o, loaded_o);
    end
    rts_i = 1'b0; rtr_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_truncated();
    test_reload();
    test_cfg_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/positron_layer_weight_sequencer.md
Name: positron_layer_weight_sequencer

Overview:
- Sequences one positron layer: stores the per-input weight rows and streams each incoming activation posit paired with its weight row.
- Generates frame-aligned start-of-word and end-of-word markers, and propagates the DMA end-of-transfer marker.
- Sits between the upstream DMA/posit stream and the positron array.
- Handles weight (re)load between frames and backpressure from the array.

Parameters:
- NB_UPSTREAM_POSITRON, 784: words per frame; also the weight memory depth.
- NB_POSITRON, 20: positrons in the layer, i.e. weights per row.
- POSIT_WIDTH, 16: activation posit width.
- WEIGHT_WIDTH, 8: width of one weight.
- FRAME_CNT_WIDTH, 16: width of the completed-frame counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we_i  in  1  weight row write strobe.
- cfg_addr_i  in  $clog2(NB_UPSTREAM_POSITRON)  row address.
- cfg_data_i  in  NB_POSITRON*WEIGHT_WIDTH  row data; positron k uses bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- cfg_commit_i  in  1  pulse: weights loaded, enter RUN.
- cfg_reload_i  in  1  pulse: request return to LOAD.
- cfg_err_o  out  1  sticky: cfg_we_i was seen outside LOAD.
- loaded_o  out  1  high while in RUN.
- rtr_o  out  1  ready to receive an input word.
- rts_i  in  1  input word valid.
- eow_i  in  1  DMA last word.
- posit_i  in  POSIT_WIDTH  activation.
- rtr_i  in  1  downstream ready.
- rts_o  out  1  output word valid.
- sow_o  out  1  output word is frame index 0.
- eow_o  out  1  output word closes the frame.
- dma_eow_o  out  1  output word was the DMA last word.
- posit_o  out  POSIT_WIDTH  registered activation.
- weights_o  out  NB_POSITRON*WEIGHT_WIDTH  weight row for posit_o.
- frame_cnt_o  out  FRAME_CNT_WIDTH  completed frames; wraps at 2^FRAME_CNT_WIDTH.

Behaviour:
- Reset values:
  - Outputs: rts_o=0, sow_o=0, eow_o=0, dma_eow_o=0, posit_o=0, weights_o=0, rtr_o=0, loaded_o=0, cfg_err_o=0, frame_cnt_o=0.
  - Internal: state=LOAD, wc=0, reload_pending=0.
  - Weight memory contents are not reset.
  - Reset asserted mid-frame discards the frame, including any in-flight output, immediately.
- States:
  - LOAD:
    - cfg_we_i writes the memory row at cfg_addr_i.
    - rtr_o=0.
    - cfg_commit_i -> RUN; wc cleared to 0.
  - RUN:
    - Streaming; loaded_o=1.
    - cfg_we_i is ignored and sets cfg_err_o.
    - cfg_reload_i sets reload_pending.
  - DRAIN:
    - Entered from RUN when reload_pending=1 and wc==0 (frame boundary); rtr_o=0.
    - -> LOAD when rts_o=0, or when rts_o & rtr_i in that cycle.
    - reload_pending is cleared on entry to LOAD.
- cfg_commit_i outside LOAD is ignored. cfg_reload_i in LOAD or DRAIN is ignored.
- Handshake:
  - In RUN with reload_pending=0 or wc!=0: rtr_o = ~rts_o | rtr_i (single output register, full throughput).
  - Accept = rts_i & rtr_o. A word is transferred out on rts_o & rtr_i.
  - rts_o sets on accept, clears on transfer-out without a simultaneous accept, and otherwise holds.
  - Output fields are stable while rts_o=1 & rtr_i=0.
- Latency: a word accepted in cycle t appears on posit_o/weights_o in cycle t+1.
  - The memory is read synchronously at address wc, with read enable = accept.
  - The memory output is the weights_o register; it holds while stalled.
- Frame indexing:
  - On accept, sow_o <= (wc==0) and eow_o <= (wc==NB_UPSTREAM_POSITRON-1) | eow_i. dma_eow_o <= eow_i.
  - wc <= 0 if eow_o-condition, else wc+1.
  - A truncated frame (eow_i before index N-1) ends at that word, and the next word is sow.
  - eow_i on wc==N-1 produces a single eow_o, not a double count.
  - If N==1, every word has sow_o=eow_o=1.
- frame_cnt_o increments by 1 on the transfer-out of a word with eow_o=1.
- Simultaneous events:
  - cfg_reload_i on the same accept that ends a frame: DRAIN is entered the next cycle.
  - cfg_commit_i and cfg_we_i in the same LOAD cycle: the write completes, then RUN.

Test Plan:
- Params N=4, P=2, W=8, rows 0..3 = 0x0101, 0x0202, 0x0303, 0x0404; commit, then stream posits 0x10..0x17 with rtr_i=1 -> 8 outputs, 1-cycle latency, weights 0x0101..0x0404 repeating; sow_o on 0x10 and 0x14; eow_o on 0x13 and 0x17; frame_cnt_o=2.
- Same setup with rtr_i low for 3 cycles while out word 0x11 is valid -> rtr_o=0 during the stall; posit_o=0x11 and weights_o=0x0202 held; no word is lost or duplicated.
- eow_i with the word at wc=1 -> that output has eow_o=1 and dma_eow_o=1; frame_cnt_o+1; the next word has sow_o=1 and weights 0x0101.
- cfg_reload_i at wc=2 -> stays in RUN until the word at wc=3 is accepted; DRAIN, then LOAD after the last transfer-out; loaded_o=0; rewrite row 0 to 0xAAAA, commit, then the first word gets weights_o=0xAAAA.
- cfg_we_i pulsed in RUN -> cfg_err_o=1 (sticky); memory unchanged; the next frame still shows 0x0101.
- rst_n pulled low mid-frame with rts_o=1 -> all outputs 0 asynchronously; after release the state is LOAD and rtr_o=0 until commit.
